// File: rtl/loop_station_pkg.sv
// Shared types and helpers for the loop station: loop/phase/op enums, output latency, saturating add.
package loop_station_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PH_A0 = 2'd0,
    PH_A1 = 2'd1,
    PH_A2 = 2'd2,
    PH_A3 = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2,
    OP_RMW  = 2'd3
  } op_t;

  localparam int LATENCY = 3;

  // Signed 16-bit add formed at 17 bits and clamped to the 16-bit range.
  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
    return s[15:0];
  endfunction

endpackage

// File: rtl/loop_sram_ctrl.sv
// SRAM access sequencer: A0/A1 strobe window, A2 release, optional A3 write-back.
// LOOPER_OVERDUB_EN enables the A3 read-modify-write phase.
module loop_sram_ctrl
  import loop_station_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              req,
  input  op_t               req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rd_data,
  output logic              capture,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [15:0]       sram_dq,
  output logic              we_n,
  output logic              ce_n,
  output logic              oe_n,
  output logic              lb_n,
  output logic              ub_n
);

  phase_t            phase_q;
  op_t               op_q;
  logic              busy_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_phase;
  logic              access;
  logic              wr_phase;
  logic              rd_phase;

`ifdef LOOPER_OVERDUB_EN
  assign last_phase = (op_q == OP_RMW) ? (phase_q == PH_A3) : (phase_q == PH_A2);
`else
  assign last_phase = (phase_q == PH_A2);
`endif

  // Capture one phase before the output slot so o_valid lands LATENCY cycles after the request.
  assign capture   = busy_q && (phase_q == phase_t'(2'(LATENCY - 2)));
  assign done      = busy_q && last_phase;
  assign busy      = busy_q;
  assign sram_addr = addr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking for all sequential state so every register samples pre-edge values.
    if (i_rst) begin
      busy_q  <= 1'b0;
      phase_q <= PH_A0;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (!busy_q) begin
      if (req) begin
        busy_q  <= 1'b1;
        phase_q <= PH_A0;
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= wdata;
      end
    end else if (last_phase) begin
      busy_q  <= 1'b0;
      phase_q <= PH_A0;
    end else begin
      phase_q <= phase_t'(phase_q + 2'd1);
      if (capture && op_q == OP_RMW) wdata_q <= wdata;
    end
  end

  // Strobes decode straight from registers so a reset releases the bus without waiting for a clock.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    access   = 1'b0;
    wr_phase = 1'b0;
    rd_phase = 1'b0;
    if (busy_q && op_q != OP_NONE) begin
      if (phase_q == PH_A0 || phase_q == PH_A1) begin
        access   = 1'b1;
        wr_phase = (op_q == OP_WR);
        rd_phase = (op_q != OP_WR);
      end else if (phase_q == PH_A3) begin
        access   = 1'b1;
        wr_phase = 1'b1;
      end
    end
  end

  assign ce_n    = ~access;
  assign lb_n    = ~access;
  assign ub_n    = ~access;
  assign we_n    = ~wr_phase;
  assign oe_n    = ~rd_phase;
  assign sram_dq = wr_phase ? wdata_q : 16'hzzzz;
  assign rd_data = sram_dq;

endmodule

// File: rtl/loop_station.sv
// Loop recorder/player: IDLE/REC/PLAY FSM, loop counters, key latch and live+loop mixing.
// LOOPER_OVERDUB_EN turns PLAY into read-modify-write overdubbing.
module loop_station
  import loop_station_pkg::*;
#(
  parameter int          ADDR_W  = 20,
  parameter int unsigned MAX_LEN = 2**20 - 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [15:0]       i_data,
  input  logic              i_loop_key,
  output logic [15:0]       o_data,
  output logic              o_valid,
  output logic [1:0]        o_state,
  output logic [ADDR_W-1:0] o_len,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [15:0]       io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  localparam logic [ADDR_W-1:0] MAX_LEN_W = ADDR_W'(MAX_LEN);

  state_t            state_q, state_d;
  op_t               req_op;
  logic [ADDR_W-1:0] req_addr, wr_addr_q, rd_addr_q, len_q;
  logic [15:0]       smp_q, o_data_q, rd_data, mix, ctrl_wdata;
  logic              o_valid_q, key_pend_q, key_now;
  logic              accept, apply, full, busy, done, capture;

  assign accept  = i_valid & ~busy;
  assign key_now = key_pend_q | i_loop_key;
  assign full    = (state_q == ST_REC) && (len_q == MAX_LEN_W);
  // A key only takes effect between accesses, so the sample in flight finishes in the old state.
  assign apply      = busy ? (done & (key_now | full)) : (key_now & ~i_valid);
  assign mix        = sat16(smp_q, rd_data);
  assign ctrl_wdata = capture ? mix : i_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    req_op   = OP_NONE;
    req_addr = rd_addr_q;
    case (state_q)
      ST_IDLE: if (apply) state_d = ST_REC;
      ST_REC: begin
        req_op   = OP_WR;
        req_addr = wr_addr_q;
        if (apply) state_d = (len_q != '0) ? ST_PLAY : ST_IDLE;
      end
      ST_PLAY: begin
`ifdef LOOPER_OVERDUB_EN
        req_op = OP_RMW;
`else
        req_op = OP_RD;
`endif
        if (apply) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      key_pend_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      len_q      <= '0;
      smp_q      <= '0;
      o_data_q   <= '0;
      o_valid_q  <= 1'b0;
    end else begin
      key_pend_q <= key_now & ~apply;
      o_valid_q  <= capture;
      if (capture) o_data_q <= (state_q == ST_PLAY) ? mix : smp_q;
      if (accept)  smp_q    <= i_data;

      if (apply && state_q == ST_IDLE) begin
        wr_addr_q <= '0;
        len_q     <= '0;
      end else if (accept && state_q == ST_REC) begin
        wr_addr_q <= wr_addr_q + 1'b1;
        len_q     <= wr_addr_q + 1'b1;
      end

      if (apply && state_d == ST_PLAY) begin
        rd_addr_q <= '0;
      end else if (accept && state_q == ST_PLAY) begin
        rd_addr_q <= (rd_addr_q == len_q - 1'b1) ? '0 : rd_addr_q + 1'b1;
      end
    end
  end

  loop_sram_ctrl #(.ADDR_W(ADDR_W)) u_sram_ctrl (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .req       (accept),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .wdata     (ctrl_wdata),
    .rd_data   (rd_data),
    .capture   (capture),
    .busy      (busy),
    .done      (done),
    .sram_addr (o_SRAM_ADDR),
    .sram_dq   (io_SRAM_DQ),
    .we_n      (o_SRAM_WE_N),
    .ce_n      (o_SRAM_CE_N),
    .oe_n      (o_SRAM_OE_N),
    .lb_n      (o_SRAM_LB_N),
    .ub_n      (o_SRAM_UB_N)
  );

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_state = state_q;
  assign o_len   = len_q;

endmodule
